// File: rtl/sram_pkg.sv
`default_nettype none
//==============================================================================
// sram_pkg : shared geometry, widths and ADC word layout for sram_arbiter
// Rev 1.0
//==============================================================================
package sram_pkg;

  localparam int H_TOTAL      = 1056;
  localparam int V_TOTAL      = 628;
  localparam int ADDR_W       = 20;
  localparam int COORD_W      = 11;
  localparam int DATA_W       = 16;
  localparam int READ_LATENCY = 3;

  localparam int ADC_WORD_W   = 38;
  localparam int ADC_X_MSB    = 37;
  localparam int ADC_X_LSB    = 27;
  localparam int ADC_Y_MSB    = 26;
  localparam int ADC_Y_LSB    = 16;
  localparam int ADC_RGB_MSB  = 15;
  localparam int ADC_RGB_LSB  = 0;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_READ = 2'd1,
    GNT_ADC  = 2'd2,
    GNT_SPI  = 2'd3
  } grant_e;

endpackage
`default_nettype wire

// File: rtl/sram_addr_calc.sv
`default_nettype none
//==============================================================================
// sram_addr_calc : pixel (x,y) to linear SRAM word address plus range check
// Rev 1.0
//==============================================================================
module sram_addr_calc #(
  parameter int H_TOTAL = sram_pkg::H_TOTAL,
  parameter int V_TOTAL = sram_pkg::V_TOTAL
) (
  input  logic [sram_pkg::COORD_W-1:0] x_i,
  input  logic [sram_pkg::COORD_W-1:0] y_i,
  output logic [sram_pkg::ADDR_W-1:0]  addr_o,
  output logic                         in_range_o
);
  import sram_pkg::*;

  localparam logic [COORD_W:0] X_LIM = (COORD_W+1)'(H_TOTAL);
  localparam logic [COORD_W:0] Y_LIM = (COORD_W+1)'(V_TOTAL);

  logic [ADDR_W-1:0] x_ext;
  logic [ADDR_W-1:0] y_ext;

  assign x_ext = ADDR_W'(x_i);
  assign y_ext = ADDR_W'(y_i);

  // 1056 = 1024 + 32, so the default stride needs only two shifts and an add.
  generate
    if (H_TOTAL == 1056) begin : g_shift_add
      assign addr_o = (y_ext << 10) + (y_ext << 5) + x_ext;
    end else begin : g_mult
      assign addr_o = y_ext * ADDR_W'(H_TOTAL) + x_ext;
    end
  endgenerate

  assign in_range_o = ({1'b0, x_i} < X_LIM) && ({1'b0, y_i} < Y_LIM);

endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
//==============================================================================
// sram_arbiter : single-port SRAM arbiter, fixed-latency reads over SPI/ADC writes
// Rev 1.0
//==============================================================================
module sram_arbiter #(
  parameter int READ_LATENCY = sram_pkg::READ_LATENCY,
  parameter int H_TOTAL      = sram_pkg::H_TOTAL,
  parameter int V_TOTAL      = sram_pkg::V_TOTAL
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [sram_pkg::ADC_WORD_W-1:0]   adc_pixel_data,
  input  logic                              adc_pixel_ready,
  output logic                              adc_pixel_read,
  input  logic                              spi_active,
  input  logic [sram_pkg::COORD_W-1:0]      spi_pixel_x,
  input  logic [sram_pkg::COORD_W-1:0]      spi_pixel_y,
  input  logic [sram_pkg::DATA_W-1:0]       spi_pixel_in,
  output logic                              spi_ack,
  input  logic                              freeze,
  input  logic                              request_active,
  input  logic [sram_pkg::COORD_W-1:0]      request_x,
  input  logic [sram_pkg::COORD_W-1:0]      request_y,
  output logic                              request_ready,
  output logic [sram_pkg::DATA_W-1:0]       request_data,
  output logic                              cmd_valid,
  output logic                              cmd_write,
  output logic [sram_pkg::ADDR_W-1:0]       cmd_addr,
  output logic [sram_pkg::DATA_W-1:0]       cmd_wdata,
  input  logic [sram_pkg::DATA_W-1:0]       sram_rdata
);
  import sram_pkg::*;

  logic [COORD_W-1:0] adc_x;
  logic [COORD_W-1:0] adc_y;
  logic [DATA_W-1:0]  adc_rgb;

  logic [ADDR_W-1:0]  rd_addr;
  logic [ADDR_W-1:0]  adc_addr;
  logic [ADDR_W-1:0]  spi_addr;
  logic               rd_ok;
  logic               adc_ok;
  logic               spi_ok;

  grant_e             grant;

  logic               rr_spi_q, rr_spi_d;
  logic               cmd_valid_q, cmd_valid_d;
  logic               cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0]  cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]  cmd_wdata_q, cmd_wdata_d;

  logic [READ_LATENCY:0]   rd_vld_q, rd_vld_d;
  logic [READ_LATENCY-1:0] rd_oor_q, rd_oor_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;

  assign adc_x   = adc_pixel_data[ADC_X_MSB:ADC_X_LSB];
  assign adc_y   = adc_pixel_data[ADC_Y_MSB:ADC_Y_LSB];
  assign adc_rgb = adc_pixel_data[ADC_RGB_MSB:ADC_RGB_LSB];

  sram_addr_calc #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_rd_addr (
    .x_i        (request_x),
    .y_i        (request_y),
    .addr_o     (rd_addr),
    .in_range_o (rd_ok)
  );

  sram_addr_calc #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_adc_addr (
    .x_i        (adc_x),
    .y_i        (adc_y),
    .addr_o     (adc_addr),
    .in_range_o (adc_ok)
  );

  sram_addr_calc #(.H_TOTAL(H_TOTAL), .V_TOTAL(V_TOTAL)) u_spi_addr (
    .x_i        (spi_pixel_x),
    .y_i        (spi_pixel_y),
    .addr_o     (spi_addr),
    .in_range_o (spi_ok)
  );

  // Reads always win; rr_spi_q only breaks ties between two pending writers.
  always_comb begin
    grant = GNT_NONE;
    if (request_active) begin
      grant = GNT_READ;
    end else if (adc_pixel_ready && spi_active) begin
      grant = rr_spi_q ? GNT_SPI : GNT_ADC;
    end else if (adc_pixel_ready) begin
      grant = GNT_ADC;
    end else if (spi_active) begin
      grant = GNT_SPI;
    end
  end

  assign adc_pixel_read = rst_n && (grant == GNT_ADC);
  assign spi_ack        = rst_n && (grant == GNT_SPI);

  // Out-of-range and frozen writes are still consumed; they just issue nothing.
  always_comb begin
    rr_spi_d    = rr_spi_q;
    cmd_valid_d = 1'b0;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    case (grant)
      GNT_READ: begin
        if (rd_ok) begin
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b0;
          cmd_addr_d  = rd_addr;
        end
      end
      GNT_ADC: begin
        rr_spi_d = 1'b1;
        if (adc_ok && !freeze) begin
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b1;
          cmd_addr_d  = adc_addr;
          cmd_wdata_d = adc_rgb;
        end
      end
      GNT_SPI: begin
        rr_spi_d = 1'b0;
        if (spi_ok) begin
          cmd_valid_d = 1'b1;
          cmd_write_d = 1'b1;
          cmd_addr_d  = spi_addr;
          cmd_wdata_d = spi_pixel_in;
        end
      end
      default: ;
    endcase
  end

  // Every read, in range or not, walks the same pipe so returns stay in order.
  always_comb begin
    rd_vld_d  = {rd_vld_q[READ_LATENCY-1:0], grant == GNT_READ};
    rd_oor_d  = READ_LATENCY'({rd_oor_q, (grant == GNT_READ) && !rd_ok});
    rd_data_d = rd_data_q;
    if (rd_vld_q[READ_LATENCY-1]) begin
      rd_data_d = rd_oor_q[READ_LATENCY-1] ? '0 : sram_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_spi_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      rd_vld_q    <= '0;
      rd_oor_q    <= '0;
      rd_data_q   <= '0;
    end else begin
      rr_spi_q    <= rr_spi_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      rd_vld_q    <= rd_vld_d;
      rd_oor_q    <= rd_oor_d;
      rd_data_q   <= rd_data_d;
    end
  end

  assign cmd_valid     = cmd_valid_q;
  assign cmd_write     = cmd_write_q;
  assign cmd_addr      = cmd_addr_q;
  assign cmd_wdata     = cmd_wdata_q;
  assign request_ready = rd_vld_q[READ_LATENCY];
  assign request_data  = rd_data_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
//==============================================================================
// tb_sram_arbiter : directed stimulus, SRAM environment and per-cycle reference model
// Rev 1.0
//==============================================================================
module tb_sram_arbiter;

  localparam int H  = 1056;
  localparam int V  = 628;
  localparam int RL = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [37:0] adc_pixel_data;
  logic        adc_pixel_ready;
  logic        adc_pixel_read;
  logic        spi_active;
  logic [10:0] spi_pixel_x;
  logic [10:0] spi_pixel_y;
  logic [15:0] spi_pixel_in;
  logic        spi_ack;
  logic        freeze;
  logic        request_active;
  logic [10:0] request_x;
  logic [10:0] request_y;
  logic        request_ready;
  logic [15:0] request_data;
  logic        cmd_valid;
  logic        cmd_write;
  logic [19:0] cmd_addr;
  logic [15:0] cmd_wdata;
  logic [15:0] sram_rdata = 16'hDEAD;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  sram_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .adc_pixel_data  (adc_pixel_data),
    .adc_pixel_ready (adc_pixel_ready),
    .adc_pixel_read  (adc_pixel_read),
    .spi_active      (spi_active),
    .spi_pixel_x     (spi_pixel_x),
    .spi_pixel_y     (spi_pixel_y),
    .spi_pixel_in    (spi_pixel_in),
    .spi_ack         (spi_ack),
    .freeze          (freeze),
    .request_active  (request_active),
    .request_x       (request_x),
    .request_y       (request_y),
    .request_ready   (request_ready),
    .request_data    (request_data),
    .cmd_valid       (cmd_valid),
    .cmd_write       (cmd_write),
    .cmd_addr        (cmd_addr),
    .cmd_wdata       (cmd_wdata),
    .sram_rdata      (sram_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // SRAM contents seen by the environment; unwritten words read back a pattern.
  logic [15:0] mem     [int];
  logic [19:0] rd_sched[int];
  logic [15:0] exp_rdy [int];

  function automatic logic [15:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'(a) ^ 16'h5A5A;
  endfunction

  logic        m_favour_spi = 1'b0;
  logic        m_cmd_valid  = 1'b0;
  logic        m_cmd_write  = 1'b0;
  logic [19:0] m_cmd_addr   = '0;
  logic [15:0] m_cmd_wdata  = '0;

  always @(negedge clk) begin : p_model
    int   a;
    int   wx;
    int   wy;
    bit   ok;
    bit   adc_win;
    logic ea;
    logic es;
    if (!rst_n) begin
      chk("reset_cmd_valid", 32'(cmd_valid), 0);
      chk("reset_cmd_write", 32'(cmd_write), 0);
      chk("reset_cmd_addr", 32'(cmd_addr), 0);
      chk("reset_cmd_wdata", 32'(cmd_wdata), 0);
      chk("reset_request_ready", 32'(request_ready), 0);
      chk("reset_request_data", 32'(request_data), 0);
      chk("reset_adc_pixel_read", 32'(adc_pixel_read), 0);
      chk("reset_spi_ack", 32'(spi_ack), 0);
      m_favour_spi = 1'b0;
      m_cmd_valid  = 1'b0;
      m_cmd_write  = 1'b0;
      m_cmd_addr   = '0;
      m_cmd_wdata  = '0;
      exp_rdy.delete();
      rd_sched.delete();
      sram_rdata = 16'hDEAD;
    end else begin
      // SRAM environment: writes land now, read data is presented in time
      // for the capture edge READ_LATENCY edges after the command edge.
      if (cmd_valid && cmd_write) mem[int'(cmd_addr)] = cmd_wdata;
      if (cmd_valid && !cmd_write) rd_sched[cyc + RL - 1] = cmd_addr;
      if (rd_sched.exists(cyc)) begin
        sram_rdata = mem_rd(int'(rd_sched[cyc]));
        rd_sched.delete(cyc);
      end else begin
        sram_rdata = 16'hDEAD;
      end

      chk("cmd_valid", 32'(cmd_valid), 32'(m_cmd_valid));
      if (m_cmd_valid) chk("cmd_write", 32'(cmd_write), 32'(m_cmd_write));
      chk("cmd_addr", 32'(cmd_addr), 32'(m_cmd_addr));
      chk("cmd_wdata", 32'(cmd_wdata), 32'(m_cmd_wdata));
      chk("request_ready", 32'(request_ready), 32'(exp_rdy.exists(cyc)));
      if (exp_rdy.exists(cyc)) begin
        chk("request_data", 32'(request_data), 32'(exp_rdy[cyc]));
        exp_rdy.delete(cyc);
      end

      m_cmd_valid = 1'b0;
      ea = 1'b0;
      es = 1'b0;
      if (request_active) begin
        wx = int'(request_x);
        wy = int'(request_y);
        a  = wy * H + wx;
        ok = (wx < H) && (wy < V);
        exp_rdy[cyc + 1 + RL] = ok ? mem_rd(a) : 16'h0000;
        if (ok) begin
          m_cmd_valid = 1'b1;
          m_cmd_write = 1'b0;
          m_cmd_addr  = 20'(a);
        end
      end else if (adc_pixel_ready || spi_active) begin
        if (adc_pixel_ready && spi_active) adc_win = !m_favour_spi;
        else                               adc_win = adc_pixel_ready;
        if (adc_win) begin
          ea = 1'b1;
          m_favour_spi = 1'b1;
          wx = int'(adc_pixel_data[37:27]);
          wy = int'(adc_pixel_data[26:16]);
          if (wx < H && wy < V && !freeze) begin
            m_cmd_valid = 1'b1;
            m_cmd_write = 1'b1;
            m_cmd_addr  = 20'(wy * H + wx);
            m_cmd_wdata = adc_pixel_data[15:0];
          end
        end else begin
          es = 1'b1;
          m_favour_spi = 1'b0;
          wx = int'(spi_pixel_x);
          wy = int'(spi_pixel_y);
          if (wx < H && wy < V) begin
            m_cmd_valid = 1'b1;
            m_cmd_write = 1'b1;
            m_cmd_addr  = 20'(wy * H + wx);
            m_cmd_wdata = spi_pixel_in;
          end
        end
      end
      chk("adc_pixel_read", 32'(adc_pixel_read), 32'(ea));
      chk("spi_ack", 32'(spi_ack), 32'(es));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spi_write(input int x, input int y, input logic [15:0] d, input logic exp_cmd);
    spi_active   = 1'b1;
    spi_pixel_x  = 11'(x);
    spi_pixel_y  = 11'(y);
    spi_pixel_in = d;
    @(negedge clk);
    chk("spi_write_ack", 32'(spi_ack), 1);
    tick();
    spi_active = 1'b0;
    @(negedge clk);
    chk("spi_write_cmd_valid", 32'(cmd_valid), 32'(exp_cmd));
    tick();
  endtask

  task automatic read_check(input int x, input int y, input logic [15:0] exp);
    request_active = 1'b1;
    request_x      = 11'(x);
    request_y      = 11'(y);
    tick();
    request_active = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("read_not_early", 32'(request_ready), 0);
    tick();
    @(negedge clk);
    chk("read_ready", 32'(request_ready), 1);
    chk("read_data", 32'(request_data), 32'(exp));
    tick();
  endtask

  task automatic adc_burst(input int n, input int y, input logic [15:0] base,
                           output int pops, output int wcmds);
    int k;
    int guard;
    k = 0; guard = 0; pops = 0; wcmds = 0;
    while (k < n && guard < 4 * n + 8) begin
      adc_pixel_ready = 1'b1;
      adc_pixel_data  = {11'(k), 11'(y), base + 16'(k)};
      @(negedge clk);
      if (cmd_valid && cmd_write) wcmds++;
      if (adc_pixel_read) begin
        pops++;
        k++;
      end
      tick();
      guard++;
    end
    adc_pixel_ready = 1'b0;
    @(negedge clk);
    if (cmd_valid && cmd_write) wcmds++;
    tick();
    chk("adc_burst_complete", 32'(k), 32'(n));
  endtask

  initial begin
    int ai;
    int si;
    int pops;
    int wcmds;
    int rdy_cnt;
    rst_n = 1'b0;
    adc_pixel_data = '0; adc_pixel_ready = 1'b0;
    spi_active = 1'b0; spi_pixel_x = '0; spi_pixel_y = '0; spi_pixel_in = '0;
    freeze = 1'b0;
    request_active = 1'b0; request_x = '0; request_y = '0;
    repeat (3) tick();
    @(negedge clk);
    chk("por_cmd_valid", 32'(cmd_valid), 0);
    chk("por_request_ready", 32'(request_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Read of (5,2) after a known SPI write: address 2*1056+5 = 2117.
    spi_write(5, 2, 16'hBEEF, 1'b1);
    request_active = 1'b1; request_x = 11'd5; request_y = 11'd2;
    tick();
    request_active = 1'b0;
    @(negedge clk);
    chk("rd52_cmd_valid", 32'(cmd_valid), 1);
    chk("rd52_cmd_write", 32'(cmd_write), 0);
    chk("rd52_cmd_addr", 32'(cmd_addr), 2117);
    tick(); tick(); tick();
    @(negedge clk);
    chk("rd52_ready", 32'(request_ready), 1);
    chk("rd52_data", 32'(request_data), 32'hBEEF);
    tick();
    @(negedge clk);
    chk("rd52_ready_one_cycle", 32'(request_ready), 0);
    tick();

    // ADC pending alongside a read: read first, ADC on the next free cycle.
    adc_pixel_ready = 1'b1;
    adc_pixel_data  = {11'd10, 11'd3, 16'h1234};
    request_active  = 1'b1; request_x = 11'd0; request_y = 11'd0;
    @(negedge clk);
    chk("adc_blocked_by_read", 32'(adc_pixel_read), 0);
    tick();
    request_active = 1'b0;
    @(negedge clk);
    chk("adc_after_read", 32'(adc_pixel_read), 1);
    tick();
    adc_pixel_ready = 1'b0;
    @(negedge clk);
    chk("adc_cmd_write", 32'(cmd_write), 1);
    chk("adc_cmd_addr", 32'(cmd_addr), 3178);
    chk("adc_cmd_wdata", 32'(cmd_wdata), 32'h1234);
    tick();
    repeat (4) tick();

    // Lone SPI write leaves SPI as last winner, so the next tie goes to ADC.
    spi_write(20, 1, 16'h0F0F, 1'b1);
    ai = 0; si = 0;
    for (int i = 0; i < 8; i++) begin
      adc_pixel_ready = 1'b1;
      adc_pixel_data  = {11'(ai), 11'd4, 16'hA000 + 16'(ai)};
      spi_active   = 1'b1;
      spi_pixel_x  = 11'(si);
      spi_pixel_y  = 11'd5;
      spi_pixel_in = 16'h5000 + 16'(si);
      @(negedge clk);
      chk("rr_adc_turn", 32'(adc_pixel_read), 32'(i % 2 == 0));
      chk("rr_spi_turn", 32'(spi_ack), 32'(i % 2 == 1));
      if (adc_pixel_read) ai++;
      if (spi_ack) si++;
      tick();
    end
    adc_pixel_ready = 1'b0;
    spi_active = 1'b0;
    tick();
    read_check(0, 4, 16'hA000);
    read_check(3, 4, 16'hA003);
    read_check(0, 5, 16'h5000);
    read_check(3, 5, 16'h5003);

    // Back-to-back reads, including an out-of-range one mid-stream.
    for (int i = 0; i < 5; i++) begin
      request_active = 1'b1;
      request_x = (i == 2) ? 11'd1500 : 11'(i);
      request_y = (i % 2 == 0) ? 11'd4 : 11'd5;
      tick();
    end
    request_active = 1'b0;
    repeat (6) tick();

    // Out-of-range read and writes.
    request_active = 1'b1; request_x = 11'd1056; request_y = 11'd0;
    tick();
    request_active = 1'b0;
    @(negedge clk);
    chk("oor_read_no_cmd", 32'(cmd_valid), 0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("oor_read_ready", 32'(request_ready), 1);
    chk("oor_read_data", 32'(request_data), 0);
    tick();
    adc_pixel_ready = 1'b1;
    adc_pixel_data  = {11'd0, 11'd628, 16'h7777};
    @(negedge clk);
    chk("oor_adc_popped", 32'(adc_pixel_read), 1);
    tick();
    adc_pixel_ready = 1'b0;
    @(negedge clk);
    chk("oor_adc_no_cmd", 32'(cmd_valid), 0);
    tick();
    spi_write(1056, 0, 16'h8888, 1'b0);

    // Freeze: ADC words are drained without touching the SRAM.
    adc_burst(8, 6, 16'hC000, pops, wcmds);
    chk("prefreeze_pops", 32'(pops), 8);
    chk("prefreeze_writes", 32'(wcmds), 8);
    freeze = 1'b1;
    adc_burst(8, 6, 16'hD000, pops, wcmds);
    chk("freeze_pops", 32'(pops), 8);
    chk("freeze_writes", 32'(wcmds), 0);
    spi_write(100, 6, 16'h1111, 1'b1);
    read_check(0, 6, 16'hC000);
    freeze = 1'b0;
    for (int i = 1; i < 8; i++) read_check(i, 6, 16'hC000 + 16'(i));
    read_check(100, 6, 16'h1111);

    // Reset with three reads in flight; strobes must stay low during reset.
    for (int i = 0; i < 3; i++) begin
      request_active = 1'b1; request_x = 11'(i); request_y = 11'd4;
      tick();
    end
    request_active  = 1'b0;
    rst_n           = 1'b0;
    adc_pixel_ready = 1'b1;
    adc_pixel_data  = {11'd0, 11'd7, 16'h1357};
    spi_active = 1'b1; spi_pixel_x = 11'd0; spi_pixel_y = 11'd8; spi_pixel_in = 16'h2468;
    @(negedge clk);
    chk("rst_hold_cmd_valid", 32'(cmd_valid), 0);
    chk("rst_hold_adc_read", 32'(adc_pixel_read), 0);
    tick();
    @(negedge clk);
    chk("rst_hold_ready", 32'(request_ready), 0);
    chk("rst_hold_spi_ack", 32'(spi_ack), 0);
    tick();
    rst_n = 1'b1;
    rdy_cnt = 0;
    @(negedge clk);
    chk("post_rst_adc_first", 32'(adc_pixel_read), 1);
    chk("post_rst_spi_wait", 32'(spi_ack), 0);
    rdy_cnt += int'(request_ready);
    tick();
    adc_pixel_data = {11'd1, 11'd7, 16'h1358};
    @(negedge clk);
    chk("post_rst_spi_second", 32'(spi_ack), 1);
    rdy_cnt += int'(request_ready);
    tick();
    adc_pixel_ready = 1'b0;
    spi_active = 1'b0;
    repeat (6) begin
      @(negedge clk);
      rdy_cnt += int'(request_ready);
      tick();
    end
    chk("no_ready_after_reset", 32'(rdy_cnt), 0);
    read_check(0, 7, 16'h1357);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got no completion by time %0t, expected completion", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter READ_LATENCY, default 3; cycles from SRAM command output to valid sram_rdata.
REQ-002 Parameter H_TOTAL, default 1056; pixels per line, address stride.
REQ-003 Parameter V_TOTAL, default 628; lines per frame.
REQ-004 Ports (name  direction  width  meaning); one clock, reset is asynchronous and active-low:
clk  in  1  160 MHz system clock.
rst_n  in  1  asynchronous active-low reset.
adc_pixel_data  in  38  ADC FIFO word: x[37:27], y[26:16], rgb565[15:0].
adc_pixel_ready  in  1  ADC FIFO non-empty, first-word-fall-through.
adc_pixel_read  out  1  combinational pop strobe to the ADC FIFO.
spi_active  in  1  SPI write valid.
spi_pixel_x  in  11  SPI write x.
spi_pixel_y  in  11  SPI write y.
spi_pixel_in  in  16  SPI write data.
spi_ack  out  1  combinational accept strobe for the SPI write.
freeze  in  1  discard ADC writes while the frame is held.
request_active  in  1  foreground read request, one pixel per asserted cycle.
request_x  in  11  read x.
request_y  in  11  read y.
request_ready  out  1  read data valid pulse.
request_data  out  16  read pixel.
cmd_valid  out  1  registered SRAM command valid.
cmd_write  out  1  1 = write, 0 = read.
cmd_addr  out  20  SRAM word address.
cmd_wdata  out  16  write data.
sram_rdata  in  16  read data from the SRAM port.

Function
REQ-005 Address SHALL be y*H_TOTAL + x, computed as (y<<10)+(y<<5)+x for the default H_TOTAL, 20 bits, no truncation for in-range coordinates.
REQ-006 Coordinate SHALL be in range iff x < H_TOTAL and y < V_TOTAL.
REQ-007 Priority each cycle SHALL be: read request > write (SPI/ADC) > idle; a read is never stalled or dropped.
REQ-008 Between ADC and SPI, when both are pending and no read is requested, the grant SHALL alternate round-robin, with a 1-bit last-winner register; a lone requester always wins.
REQ-009 adc_pixel_read/spi_ack SHALL be asserted in the grant cycle only, never when the input is not ready/active.
REQ-010 A granted operation SHALL appear on cmd_* on the next cycle, registered; cmd_valid low otherwise, with cmd_addr/cmd_wdata holding their previous values.
REQ-011 A read SHALL produce request_ready high for exactly one cycle, 1+READ_LATENCY cycles (4 by default) after the request_active cycle, with request_data = sram_rdata registered at that point.
REQ-012 Back-to-back read requests SHALL each return in order, at the same fixed latency, via a READ_LATENCY+1-deep valid/out-of-range shift pipeline.
REQ-013 An out-of-range read SHALL issue no SRAM command and SHALL still return request_ready at the normal latency with request_data = 16'h0000.
REQ-014 An out-of-range write SHALL be popped/acked in its grant cycle and SHALL issue no SRAM command.
REQ-015 While freeze=1, ADC words SHALL be popped when they would have been granted, with no SRAM command issued; SPI writes and reads SHALL be unaffected.
REQ-016 A change of freeze SHALL take effect on the next arbitration cycle; a write already on cmd_* completes.

Reset
REQ-017 While rst_n=0, all registered outputs SHALL be 0, the latency pipeline SHALL be cleared, and the round-robin pointer SHALL favour ADC.
REQ-018 Reads in flight at reset SHALL be abandoned: no request_ready after release.
REQ-019 Combinational strobes SHALL be 0 while rst_n=0.

Structure
REQ-020 H_TOTAL, V_TOTAL, ADDR_W=20, pixel field bit positions and READ_LATENCY default SHALL live in shared package sram_pkg.
REQ-021 Address computation plus range check SHALL be one sub-module sram_addr_calc, instantiated once per requester.

Verification
REQ-022 Read (x=5,y=2) at cycle 0 -> cmd_addr=2117, cmd_write=0 at cycle 1; request_ready with the model data at cycle 4.
REQ-023 ADC and request_active both high in the same cycle -> read issued, adc_pixel_read=0; ADC granted on the first read-free cycle.
REQ-024 ADC and SPI continuously pending, no reads -> grants alternate ADC,SPI,ADC...; the SRAM model holds both data sets.
REQ-025 Read (x=1056,y=0) -> no cmd_valid; request_ready at cycle 4 with data 0; ADC write y=628 popped, no command.
REQ-026 freeze=1 with 8 ADC words -> 8 pops, zero write commands; reads return the pre-freeze contents.
REQ-027 3 reads in flight, then rst_n low for 2 cycles -> outputs 0, no request_ready after release.
